ps2_scancode_rx: RTL and testbench

PS/2 keyboard receiver and scancode framer in the NPC peripheral path. It deserialises 11-bit PS/2 frames and folds the E0 (extended) and F0 (break) prefixes into per-key flags. Completed keys are buffered in a small FIFO. Its `out_code` output is the key into the `MuxKeyWithDefault` scancode→ASCII / seven-segment lookup stage directly downstream.

---
 rtl/ps2_scancode_rx_if.sv | 22 ++
 rtl/ps2_scancode_rx.sv | 244 ++++++++++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_scancode_rx_if.sv
// ----------------------------------------------------------------------------
// ps2_scancode_rx_if
// Key-event stream from the PS/2 scancode receiver to the scancode lookup.
//   out_valid : a key event is available at the head of the receive FIFO
//   out_ready : consumer takes the head event this cycle
//   out_code  : scancode of the head event
//   out_brk   : head event is a key release (F0-prefixed)
//   out_ext   : head event is an extended key (E0-prefixed)
// master = receiver side, slave = consumer side.
// ----------------------------------------------------------------------------
interface ps2_scancode_rx_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_code;
  logic       out_brk;
  logic       out_ext;

  modport master (output out_valid, output out_code, output out_brk,
                  output out_ext, input out_ready);
  modport slave  (input out_valid, input out_code, input out_brk,
                  input out_ext, output out_ready);
endinterface

// File: rtl/ps2_scancode_rx.sv
// ----------------------------------------------------------------------------
// ps2_scancode_rx
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, deserialises
// 11-bit frames (start, 8 data LSB first, odd parity, stop), folds E0/F0
// prefixes into per-key flags and queues completed keys in a show-ahead FIFO.
// Ports:
//   clk, rst_n     : system clock, asynchronous active-low reset
//   ps2_clk_i      : raw PS/2 clock (asynchronous)
//   ps2_data_i     : raw PS/2 data (asynchronous)
//   out_if         : key-event stream (valid/ready, code, brk, ext)
//   overflow_o     : sticky, a key was dropped because the FIFO was full
//   frame_err_o    : one-cycle pulse on a bad frame or a mid-frame timeout
// ----------------------------------------------------------------------------
module ps2_scancode_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ps2_clk_i,
  input  logic              ps2_data_i,
  ps2_scancode_rx_if.master out_if,
  output logic              overflow_o,
  output logic              frame_err_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_e;

  // Frame layout in the shift register: [9]=stop, [8]=parity, [7:0]=data.
  // Valid when the stop bit is 1 and data plus parity hold an odd number of 1s.
  function automatic logic frame_ok(input logic [9:0] frame);
    return frame[9] & (^frame[8:0]);
  endfunction

  // ---------------------------------------------------------------- sync
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   fall_s;
  logic                   data_s;

  // Synchroniser chains for both PS/2 lines plus the previous-clock flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= '0;
      data_sync_q <= '0;
      clk_prev_q  <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign fall_s = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------- framer
  state_e        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          brk_pend_q, brk_pend_d;
  logic          ext_pend_q, ext_pend_d;
  logic          frame_err_q, frame_err_d;
  logic          push_s;

  // Framer state, bit counter, shift register, timeout and prefix flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 10'd0;
      tmo_q       <= '0;
      brk_pend_q  <= 1'b0;
      ext_pend_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tmo_q       <= tmo_d;
      brk_pend_q  <= brk_pend_d;
      ext_pend_q  <= ext_pend_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Framer next-state: sampling on falling edges, timeout, frame check.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tmo_d       = tmo_q;
    brk_pend_d  = brk_pend_q;
    ext_pend_d  = ext_pend_q;
    frame_err_d = 1'b0;
    push_s      = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        // A high data bit on a falling edge is a false start and is ignored.
        if (fall_s && !data_s) begin
          state_d   = RECV;
          bit_cnt_d = 4'd1;
        end else begin
          state_d = IDLE;
        end
      end
      RECV: begin
        if (fall_s) begin
          tmo_d     = '0;
          shift_d   = {data_s, shift_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd10) begin
            state_d = CHECK;
          end else begin
            state_d = RECV;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Keyboard stalled mid-frame: abandon it and any pending prefix.
          state_d     = IDLE;
          tmo_d       = '0;
          frame_err_d = 1'b1;
          brk_pend_d  = 1'b0;
          ext_pend_d  = 1'b0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (frame_ok(shift_q)) begin
          if (shift_q[7:0] == 8'hF0) begin
            brk_pend_d = 1'b1;
          end else if (shift_q[7:0] == 8'hE0) begin
            ext_pend_d = 1'b1;
          end else begin
            push_s     = 1'b1;
            brk_pend_d = 1'b0;
            ext_pend_d = 1'b0;
          end
        end else begin
          frame_err_d = 1'b1;
          brk_pend_d  = 1'b0;
          ext_pend_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- FIFO
  // Entry layout: [9]=ext, [8]=brk, [7:0]=code.
  logic [9:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        overflow_q, overflow_d;
  logic        empty_s, full_s, pop_s, wr_en_s;
  logic [9:0]  head_s;

  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_s   = !empty_s && out_if.out_ready;
  // A pop in the same cycle frees the slot, so a push while full still fits.
  assign wr_en_s = push_s && (!full_s || pop_s);

  // FIFO pointer and overflow next-state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s && !wr_en_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // FIFO pointers and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage; contents are qualified by the pointers so need no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {ext_pend_q, brk_pend_q, shift_q[7:0]};
    end
  end

  assign head_s = mem_q[rd_ptr_q[AW-1:0]];

  // Show-ahead head entry, forced to zero while the FIFO is empty.
  always_comb begin
    out_if.out_code = 8'd0;
    out_if.out_brk  = 1'b0;
    out_if.out_ext  = 1'b0;
    if (!empty_s) begin
      out_if.out_code = head_s[7:0];
      out_if.out_brk  = head_s[8];
      out_if.out_ext  = head_s[9];
    end else begin
      out_if.out_code = 8'd0;
      out_if.out_brk  = 1'b0;
      out_if.out_ext  = 1'b0;
    end
  end

  assign out_if.out_valid = !empty_s;
  assign overflow_o       = overflow_q;
  assign frame_err_o      = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// ----------------------------------------------------------------------------
// tb_ps2_scancode_rx
// Randomised PS/2 frames against a queue-based model of the key stream.
// ----------------------------------------------------------------------------
module tb_ps2_scancode_rx;
  localparam int DEPTH = 8;
  localparam int SYNC  = 3;
  localparam int TMO   = 200;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;
  logic overflow;
  logic frame_err;

  ps2_scancode_rx_if out_if ();

  ps2_scancode_rx #(
    .FIFO_DEPTH    (DEPTH),
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk_i  (ps2_clk),
    .ps2_data_i (ps2_data),
    .out_if     (out_if.master),
    .overflow_o (overflow),
    .frame_err_o(frame_err)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // model: queued {ext, brk, code} entries plus pending prefixes and overflow
  logic [9:0] exp_q[$];
  logic       m_brk = 1'b0;
  logic       m_ext = 1'b0;
  logic       m_ovf = 1'b0;
  int         half  = 4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] head();
    return {out_if.out_ext, out_if.out_brk, out_if.out_code};
  endfunction

  // Apply one completed frame to the model; 'popped' = consumer took the head
  // in the same cycle the frame completed.
  task automatic model_frame(input logic [7:0] code, input bit ok, input bit popped);
    if (popped) void'(exp_q.pop_front());
    if (!ok) begin
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else if (code == 8'hF0) begin
      m_brk = 1'b1;
    end else if (code == 8'hE0) begin
      m_ext = 1'b1;
    end else begin
      if (exp_q.size() < DEPTH) exp_q.push_back({m_ext, m_brk, code});
      else m_ovf = 1'b1;
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Full frame; the stop bit is timed so the frame result can be checked on
  // the exact cycle it is due, optionally popping on that same edge.
  task automatic send_frame(input logic [7:0] code, input bit bad_par,
                            input bit bad_stop, input bit pop);
    logic par;
    bit   ok;
    par  = ~(^code) ^ bad_par;
    ok   = !bad_par && !bad_stop;
    half = $urandom_range(3, 8);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit(par);
    @(negedge clk);
    ps2_data = !bad_stop;
    repeat (half) @(negedge clk);
    ps2_clk = 1'b0;
    // first posedge after this is edge E; the result lands at edge E+SYNC+1
    for (int k = 1; k <= SYNC + 2; k++) begin
      @(posedge clk);
      if (k == SYNC + 1) begin
        #1;
        check("err_early", frame_err, 1'b0);
        if (pop) begin
          check("pop_head_valid", out_if.out_valid, 1'b1);
          check("pop_head", head(), exp_q[0]);
          out_if.out_ready = 1'b1;
        end
      end
    end
    #1;
    out_if.out_ready = 1'b0;
    model_frame(code, ok, pop);
    check("frame_err", frame_err, !ok);
    check("overflow", overflow, m_ovf);
    @(posedge clk);
    #1;
    check("err_pulse_len", frame_err, 1'b0);
    repeat (half) @(negedge clk);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  // Pop everything the model expects, one entry at a time.
  task automatic drain();
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      check("head_valid", out_if.out_valid, 1'b1);
      check("head_entry", head(), exp_q[0]);
      out_if.out_ready = 1'b1;
      @(negedge clk);
      out_if.out_ready = 1'b0;
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    check("drained_valid", out_if.out_valid, 1'b0);
    check("drained_head", head(), 10'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] code;
    int         r;
    int         pulses;
    out_if.out_ready = 1'b0;

    #1;
    check("rst_valid", out_if.out_valid, 1'b0);
    check("rst_head", head(), 10'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // basic key, break prefix, extended+break, and bad parity clearing flags
    send_frame(8'h1C, 0, 0, 0); drain();
    send_frame(8'hF0, 0, 0, 0); send_frame(8'h1C, 0, 0, 0); drain();
    send_frame(8'hE0, 0, 0, 0); send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h75, 0, 0, 0); drain();
    send_frame(8'hF0, 0, 0, 0); send_frame(8'h1C, 1, 0, 0); drain();
    send_frame(8'h1C, 0, 0, 0); drain();

    // random traffic with prefixes, parity and stop errors
    for (int i = 0; i < 40; i++) begin
      r    = $urandom_range(0, 9);
      code = 8'($urandom);
      if (r == 0) code = 8'hF0;
      else if (r == 1) code = 8'hE0;
      send_frame(code, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0, 0);
      if (exp_q.size() >= 5 || $urandom_range(0, 3) == 0) drain();
    end
    drain();

    // push landing with a pop while full: accepted, no overflow
    for (int i = 0; i < DEPTH; i++) send_frame(8'h10 + 8'(i), 0, 0, 0);
    send_frame(8'h18, 0, 0, 1);
    drain();

    // nine keys into a depth-8 FIFO: the ninth is dropped
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 0);
    drain();

    // timeout mid-frame after a break prefix
    send_frame(8'hF0, 0, 0, 0);
    half = 4;
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    pulses = 0;
    for (int c = 0; c < TMO + SYNC + 40; c++) begin
      @(negedge clk);
      if (frame_err) pulses++;
    end
    check("tmo_pulses", pulses, 1);
    m_brk = 1'b0;
    m_ext = 1'b0;
    send_frame(8'h1C, 0, 0, 0); drain();

    // reset mid-frame with two entries queued and overflow set
    send_frame(8'h11, 0, 0, 0); send_frame(8'h22, 0, 0, 0);
    half = 4;
    for (int i = 0; i < 5; i++) ps2_bit(i == 0 ? 1'b0 : 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_if.out_valid, 1'b0);
    check("mid_rst_head", head(), 10'd0);
    check("mid_rst_overflow", overflow, 1'b0);
    check("mid_rst_frame_err", frame_err, 1'b0);
    exp_q.delete();
    m_brk = 1'b0;
    m_ext = 1'b0;
    m_ovf = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h2A, 0, 0, 0); drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
